// File: rtl/bomb_controller.sv
// Single-bomb controller: snaps the player's hitbox to the arena grid on a drop,
// runs the fuse, then the explosion, and returns to idle.
module bomb_controller #(
    parameter int unsigned FUSE_MAX = 150000000,
    parameter int unsigned EXP_MAX  = 25000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] x_b,
    input  logic [9:0] y_b,
    input  logic       bomb_btn,
    input  logic       gameover,
    output logic [9:0] bomb_x,
    output logic [9:0] bomb_y,
    output logic       bomb_active,
    output logic       exp_active,
    output logic       exp_start
);

    localparam int unsigned CW = 10;
    localparam int unsigned TW = 28;

    localparam logic [CW-1:0] ORG_X   = CW'(48);
    localparam logic [CW-1:0] ORG_Y   = CW'(32);
    localparam logic [CW-1:0] OFF_X   = CW'(8);
    localparam logic [CW-1:0] OFF_Y   = CW'(17);
    localparam logic [CW-1:0] MAX_COL = CW'(32);
    localparam logic [CW-1:0] MAX_ROW = CW'(25);

    localparam logic [TW-1:0] FUSE_LAST = TW'(FUSE_MAX - 1);
    localparam logic [TW-1:0] EXP_LAST  = TW'(EXP_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_EXPLODE = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          btn_prev_q, btn_prev_d;
    logic [CW-1:0] bomb_x_q, bomb_x_d;
    logic [CW-1:0] bomb_y_q, bomb_y_d;

    logic          drop;
    logic [CW-1:0] sum_x, sum_y, cx, cy, col, row, snap_x, snap_y;

    // Hitbox-centre to grid tile, clamped to the arena on both sides.
    always_comb begin
        sum_x  = x_b + OFF_X;
        sum_y  = y_b + OFF_Y;
        cx     = (sum_x < ORG_X) ? '0 : (sum_x - ORG_X);
        cy     = (sum_y < ORG_Y) ? '0 : (sum_y - ORG_Y);
        col    = cx >> 4;
        row    = cy >> 4;
        if (col > MAX_COL) col = MAX_COL;
        if (row > MAX_ROW) row = MAX_ROW;
        snap_x = ORG_X + (col << 4);
        snap_y = ORG_Y + (row << 4);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            btn_prev_q <= 1'b1;
            bomb_x_q   <= '0;
            bomb_y_q   <= '0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            btn_prev_q <= btn_prev_d;
            bomb_x_q   <= bomb_x_d;
            bomb_y_q   <= bomb_y_d;
        end
    end

    // Next state; gameover outranks the fuse/explosion timeouts.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bomb_x_d   = bomb_x_q;
        bomb_y_d   = bomb_y_q;
        btn_prev_d = bomb_btn;
        drop       = bomb_btn & ~btn_prev_q;
        case (state_q)
            S_IDLE: begin
                if (drop && !gameover) begin
                    state_d  = S_ARMED;
                    timer_d  = '0;
                    bomb_x_d = snap_x;
                    bomb_y_d = snap_y;
                end
            end
            S_ARMED: begin
                if (gameover) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == FUSE_LAST) begin
                    state_d = S_EXPLODE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_EXPLODE: begin
                if (gameover || (timer_q == EXP_LAST)) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Outputs decode registered state only.
    always_comb begin
        bomb_x      = bomb_x_q;
        bomb_y      = bomb_y_q;
        bomb_active = (state_q == S_ARMED);
        exp_active  = (state_q == S_EXPLODE);
        exp_start   = (state_q == S_EXPLODE) && (timer_q == '0);
    end

endmodule

// File: doc/bomb_controller.md
BOMB_CONTROLLER -- requirements
Module: bomb_controller

Interface
REQ-001 Parameter FUSE_MAX, default 150000000: cycles a placed bomb stays armed before exploding.
REQ-002 Parameter EXP_MAX, default 25000000: cycles the explosion stays active.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset: one clock, reset asynchronous and active-low; logic is in reset while reset==0.
REQ-005 x_b, y_b  input  10 each  sprite top-left arena coordinates from the movement stage; the hitbox is 16x16 starting at (x_b, y_b+9).
REQ-006 bomb_btn  input  1  drop-bomb button, level, already synchronous to clk.
REQ-007 gameover  input  1  asserted when game lives == 0.
REQ-008 bomb_x, bomb_y  output  10 each  grid-snapped top-left screen coordinates of the bomb tile.
REQ-009 bomb_active  output  1  high while state is ARMED.
REQ-010 exp_active  output  1  high while state is EXPLODE.
REQ-011 exp_start  output  1  one-cycle pulse on the first cycle of EXPLODE.

Function
REQ-012 FSM states: IDLE, ARMED, EXPLODE. There is a single bomb; no queueing.
REQ-013 Drop edge: btn_prev is registered from bomb_btn every cycle; drop = bomb_btn & ~btn_prev.
REQ-014 IDLE->ARMED on a clock edge where drop==1 and gameover==0.
- On that edge: latch bomb_x, bomb_y; clear the 28-bit timer to 0.
- bomb_active goes high on the next cycle.
REQ-015 Snapping arithmetic is 10-bit.
- cx = x_b+8-48, clamped to 0 if x_b+8<48; col = cx>>4, clamped to max 32.
- cy = y_b+17-32, clamped to 0 if y_b+17<32; row = cy>>4, clamped to max 25.
- bomb_x = 48+16*col; bomb_y = 32+16*row.
REQ-016 ARMED: timer increments each cycle; at timer==FUSE_MAX-1, go to EXPLODE and clear the timer. ARMED lasts exactly FUSE_MAX cycles.
REQ-017 EXPLODE: timer increments each cycle; at timer==EXP_MAX-1, go to IDLE and clear the timer. EXPLODE lasts exactly EXP_MAX cycles.
REQ-018 exp_start is high only in the first EXPLODE cycle.
REQ-019 bomb_x/bomb_y hold their values through ARMED and EXPLODE and after returning to IDLE, until the next drop.
REQ-020 Drop edges in ARMED or EXPLODE are ignored and are not remembered.
REQ-021 A button still held when the FSM returns to IDLE does not re-arm; a new rising edge is required.
REQ-022 gameover==1 in ARMED or EXPLODE forces IDLE on the next edge, clears the timer, and suppresses exp_start.
REQ-023 gameover==1 in IDLE blocks drops.
REQ-024 Outputs are registered or decoded directly from state; no combinational path from inputs to outputs.

Reset
REQ-025 While reset==0: state=IDLE, timer=0, bomb_x=0, bomb_y=0, bomb_active=0, exp_active=0, exp_start=0, btn_prev=1.
REQ-026 btn_prev resets to 1 so a button held through reset does not drop a bomb.
REQ-027 Reset asserted mid-ARMED or mid-EXPLODE clears all state immediately, without waiting for a clock edge.
REQ-028 After reset is released, the first drop needs a fresh rising edge of bomb_btn.

Verification (bench uses FUSE_MAX=10, EXP_MAX=4)
REQ-029 Hold reset low, toggle bomb_btn -> all outputs 0 and bomb_x=bomb_y=0; release with bomb_btn high -> no drop until bomb_btn falls and rises.
REQ-030 x_b=64, y_b=23, rising edge at cycle t ->
- bomb_x=64, bomb_y=32.
- bomb_active high for cycles t+1..t+10.
- exp_start and exp_active high at t+11; exp_active high for t+11..t+14.
- IDLE at t+15.
REQ-031 x_b=561, y_b=439, drop -> col clamps to 32 (bomb_x=560), row clamps from 26 to 25 (bomb_y=432). Also x_b=48, y_b=23 -> bomb_x=48, bomb_y=32.
REQ-032 Drop, move x_b/y_b and pulse bomb_btn repeatedly during ARMED/EXPLODE ->
- bomb_x/bomb_y unchanged; timing identical to REQ-030.
- Button held across the return to IDLE -> stays IDLE.
REQ-033 Assert gameover at ARMED timer==5 -> IDLE next cycle, exp_start never pulses; drop edges while gameover==1 are ignored.
REQ-034 Pull reset low asynchronously mid-EXPLODE (between clock edges) -> exp_active and state clear immediately; after release, behaviour as REQ-029.
